// File: rtl/pawn_eval_pkg.sv
// Shared definitions for the pawn piece-square scorer: table geometry,
// FSM state encoding and the packed-table entry accessor.
package pawn_eval_pkg;

    localparam int          PST_ENTRY_W = 6;
    localparam int          NUM_SQ      = 64;
    localparam int          SQ_IDX_W    = 6;
    localparam logic [5:0]  MIRROR_MASK = 6'd56;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Square n lives at bits [6n+5:6n] of the packed table.
    function automatic logic signed [PST_ENTRY_W-1:0] pst_entry(
        input logic [NUM_SQ*PST_ENTRY_W-1:0] map,
        input logic [SQ_IDX_W-1:0]           sq
    );
        return signed'(map[sq*PST_ENTRY_W +: PST_ENTRY_W]);
    endfunction

endpackage

// File: rtl/pawn_map_scorer_if.sv
// Request/result bundle between the eval pipeline and the pawn scorer.
// The master drives the boards, table and start; the slave returns status and score.
interface pawn_map_scorer_if #(
    parameter int SCORE_W = 14
);
    import pawn_eval_pkg::*;

    logic                                start;
    logic [NUM_SQ-1:0]                   white_pawns;
    logic [NUM_SQ-1:0]                   black_pawns;
    logic [NUM_SQ*PST_ENTRY_W-1:0]       map_in;
    logic                                busy;
    logic                                done;
    logic signed [SCORE_W-1:0]           score;

    modport master (
        output start, white_pawns, black_pawns, map_in,
        input  busy, done, score
    );

    modport slave (
        input  start, white_pawns, black_pawns, map_in,
        output busy, done, score
    );
endinterface

// File: rtl/pst_group_sum.sv
// Combinational delta for one scan group: white entries added, black
// entries (rank-mirrored) subtracted, all at full score width.
module pst_group_sum
    import pawn_eval_pkg::*;
#(
    parameter int SQ_PER_CYCLE = 8,
    parameter int SCORE_W      = 14
) (
    input  logic [NUM_SQ*PST_ENTRY_W-1:0] i_map,
    input  logic [SQ_IDX_W-1:0]           i_idx,
    input  logic [SQ_PER_CYCLE-1:0]       i_white,
    input  logic [SQ_PER_CYCLE-1:0]       i_black,
    output logic signed [SCORE_W-1:0]     o_delta
);

    logic signed [SCORE_W-1:0] w_sum;

    // Sum every occupied square of the group; sign extension comes from
    // assigning the signed 6-bit entry into the wider signed temporaries.
    always_comb begin
        logic [SQ_IDX_W-1:0]       sq;
        logic signed [SCORE_W-1:0] ev_w;
        logic signed [SCORE_W-1:0] ev_b;
        w_sum = '0;
        sq    = '0;
        ev_w  = '0;
        ev_b  = '0;
        for (int k = 0; k < SQ_PER_CYCLE; k++) begin
            sq   = i_idx + SQ_IDX_W'(k);
            ev_w = pst_entry(i_map, sq);
            ev_b = pst_entry(i_map, sq ^ MIRROR_MASK);
            if (i_white[k]) w_sum = w_sum + ev_w;
            if (i_black[k]) w_sum = w_sum - ev_b;
        end
    end

    assign o_delta = w_sum;

endmodule

// File: rtl/pawn_map_scorer.sv
// Pawn positional term: scans latched white/black bitboards SQ_PER_CYCLE
// squares per clock against the packed piece-square table and reports a
// white-minus-black score with a one-cycle done pulse.
// Optional macro PAWN_SCORE_EARLY_EXIT_EN: finish the scan as soon as both
// remaining board slices are empty.
module pawn_map_scorer
    import pawn_eval_pkg::*;
#(
    parameter int SQ_PER_CYCLE = 8,
    parameter int SCORE_W      = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    pawn_map_scorer_if.slave  bus
);

    state_t                    r_state;
    logic [NUM_SQ-1:0]         r_white;
    logic [NUM_SQ-1:0]         r_black;
    logic [SQ_IDX_W-1:0]       r_idx;
    logic signed [SCORE_W-1:0] r_acc;
    logic signed [SCORE_W-1:0] r_score;
    logic                      r_busy;
    logic                      r_done;

    logic signed [SCORE_W-1:0] w_delta;
    logic [SQ_IDX_W-1:0]       w_idx_nxt;
    logic [NUM_SQ-1:0]         w_white_nxt;
    logic [NUM_SQ-1:0]         w_black_nxt;
    logic                      w_last;

    pst_group_sum #(
        .SQ_PER_CYCLE (SQ_PER_CYCLE),
        .SCORE_W      (SCORE_W)
    ) u_group (
        .i_map   (bus.map_in),
        .i_idx   (r_idx),
        .i_white (r_white[SQ_PER_CYCLE-1:0]),
        .i_black (r_black[SQ_PER_CYCLE-1:0]),
        .o_delta (w_delta)
    );

    assign w_idx_nxt   = r_idx + SQ_IDX_W'(SQ_PER_CYCLE);
    assign w_white_nxt = r_white >> SQ_PER_CYCLE;
    assign w_black_nxt = r_black >> SQ_PER_CYCLE;

`ifdef PAWN_SCORE_EARLY_EXIT_EN
    // Nothing left to score once both shifted boards are empty.
    assign w_last = (w_idx_nxt == '0) || ((w_white_nxt == '0) && (w_black_nxt == '0));
`else
    // Index wraps to zero exactly after the 64th square.
    assign w_last = (w_idx_nxt == '0);
`endif

    // Scan FSM with registered busy/done/score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_white <= '0;
            r_black <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_score <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_white <= bus.white_pawns;
                        r_black <= bus.black_pawns;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc   <= r_acc + w_delta;
                    r_idx   <= w_idx_nxt;
                    r_white <= w_white_nxt;
                    r_black <= w_black_nxt;
                    if (w_last) r_state <= DONE;
                end
                DONE: begin
                    r_score <= r_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.score = r_score;

endmodule

// File: tb/tb_pawn_map_scorer.sv
// Directed bench for pawn_map_scorer: a table of boards with hand-computed
// scores on an 8-square/cycle instance, a 1-square/cycle instance for the
// slow path, and hand-written start-ignore and mid-scan reset sequences.
module tb_pawn_map_scorer;

    localparam int SW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pawn_map_scorer_if #(.SCORE_W(SW)) if8 ();
    pawn_map_scorer_if #(.SCORE_W(SW)) if1 ();

    pawn_map_scorer #(.SQ_PER_CYCLE(8), .SCORE_W(SW)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    pawn_map_scorer #(.SQ_PER_CYCLE(1), .SCORE_W(SW)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct {
        string       name;
        logic [63:0] w;
        logic [63:0] b;
        int          exp_score;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    // Default entry (sq % 7) - 3, with the squares the vectors rely on pinned.
    function automatic logic [383:0] build_map();
        logic [383:0] m;
        int v;
        m = '0;
        for (int sq = 0; sq < 64; sq++) begin
            v = (sq % 7) - 3;
            case (sq)
                8:  v = 0;
                9:  v = -10;
                10: v = -8;
                11: v = -14;
                12: v = -32;
                13: v = 0;
                14: v = 0;
                15: v = 0;
                27: v = 8;
                48: v = 5;
                56: v = -32;
                63: v = 31;
                default: ;
            endcase
            m[sq*6 +: 6] = 6'(v);
        end
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One scan on the chosen instance; latency counted in edges after the start edge.
    task automatic run(input int which, input logic [63:0] w, input logic [63:0] b,
                       output int lat, output int sc);
        logic d;
        @(negedge clk);
        if8.white_pawns = w; if8.black_pawns = b;
        if1.white_pawns = w; if1.black_pawns = b;
        if (which == 1) if1.start = 1'b1; else if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0; if1.start = 1'b0;
        // Boards may change after the start edge with no effect.
        if8.white_pawns = ~w; if8.black_pawns = ~b;
        if1.white_pawns = ~w; if1.black_pawns = ~b;
        lat = 0;
        d   = 1'b0;
        while (!d && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            d = (which == 1) ? if1.done : if8.done;
        end
        if (!d) check("scan_timeout", lat, -1);
        sc = (which == 1) ? int'(if1.score) : int'(if8.score);
    endtask

    initial begin
        int lat, sc, busy_bad;
        logic d;

        vecs[0] = '{"initial_pos",  64'h0000_0000_0000_FF00, 64'h00FF_0000_0000_0000,   0};
        vecs[1] = '{"white_e2",     64'h0000_0000_0000_1000, 64'h0,                    -32};
        vecs[2] = '{"black_e7",     64'h0,                   64'h0010_0000_0000_0000,  32};
        vecs[3] = '{"a7_vs_d5",     64'h0001_0000_0000_0000, 64'h0000_0008_0000_0000,  -3};
        vecs[4] = '{"h8_vs_a1",     64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,  63};
        vecs[5] = '{"same_square",  64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, -32};
        vecs[6] = '{"a1b1_vs_g8",   64'h0000_0000_0000_0003, 64'h4000_0000_0000_0000,  -8};
        vecs[7] = '{"empty",        64'h0,                   64'h0,                      0};

        if8.start = 1'b0; if1.start = 1'b0;
        if8.white_pawns = '0; if8.black_pawns = '0;
        if1.white_pawns = '0; if1.black_pawns = '0;
        if8.map_in = build_map();
        if1.map_in = build_map();

        repeat (2) @(negedge clk);
        check("reset_busy",  int'(if8.busy),  0);
        check("reset_done",  int'(if8.done),  0);
        check("reset_score", int'(if8.score), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run(8, vecs[i].w, vecs[i].b, lat, sc);
            check({vecs[i].name, "_score"}, sc, vecs[i].exp_score);
`ifndef PAWN_SCORE_EARLY_EXIT_EN
            check({vecs[i].name, "_latency"}, lat, 9);
`endif
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, int'(if8.done), 0);
        end

        // Slow path: one square per clock, same result.
        run(1, vecs[3].w, vecs[3].b, lat, sc);
        check("sq1_a7_vs_d5_score", sc, -3);
`ifndef PAWN_SCORE_EARLY_EXIT_EN
        check("sq1_latency", lat, 65);
`endif
        run(1, vecs[0].w, vecs[0].b, lat, sc);
        check("sq1_initial_score", sc, 0);

        // start during SCAN with other boards must be ignored.
        @(negedge clk);
        if8.white_pawns = vecs[1].w; if8.black_pawns = vecs[1].b;
        if8.start = 1'b1;
        @(posedge clk);
        #1 if8.start = 1'b0;
        lat = 0; d = 1'b0; busy_bad = 0;
        while (!d && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            d = if8.done;
            if (!d && !if8.busy) busy_bad++;
            if (lat == 2) begin
                if8.white_pawns = vecs[4].w; if8.black_pawns = vecs[4].b;
                if8.start = 1'b1;
            end else begin
                if8.start = 1'b0;
            end
        end
        check("ignore_start_score", int'(if8.score), -32);
        check("ignore_start_busy_drops", busy_bad, 0);
`ifndef PAWN_SCORE_EARLY_EXIT_EN
        check("ignore_start_latency", lat, 9);
`endif
        @(negedge clk);
        check("ignore_start_no_requeue", int'(if8.busy), 0);

        // Reset in the middle of a scan aborts it.
        @(negedge clk);
        if8.white_pawns = vecs[3].w; if8.black_pawns = vecs[3].b;
        if8.start = 1'b1;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_abort_busy", int'(if8.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  int'(if8.busy),  0);
        check("abort_done",  int'(if8.done),  0);
        check("abort_score", int'(if8.score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8, vecs[3].w, vecs[3].b, lat, sc);
        check("post_abort_score", sc, -3);

`ifdef PAWN_SCORE_EARLY_EXIT_EN
        run(8, 64'h0, 64'h0, lat, sc);
        check("early_empty_latency", lat, 2);
        check("early_empty_score", sc, 0);
        run(8, 64'h0000_0000_0000_8000, 64'h0, lat, sc);
        check("early_h2_latency", lat, 3);
        check("early_h2_score", sc, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
